// File: rtl/board_scan_ctrl_pkg.sv
// Shared definitions for the LED board scan path: FSM state encodings and a
// constant-evaluable ceil(log2) used to size counters and row indices.
package board_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHOW    = 3'd3,
    S_BLANK   = 3'd4
  } scan_state_e;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < v) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/board_scan_ctrl_scan_timer.sv
// Loadable down-counter shared by the dwell and blanking phases. It holds at
// zero; the zero flag marks the last cycle of the current phase.
module scan_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // Counter register: load has priority over decrement, never wraps below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign value = cnt_r;
  assign zero  = (cnt_r == '0);

endmodule

// File: rtl/board_scan_ctrl.sv
// Row-scan controller for the Connect4 LED matrix. Each row is fetched from
// board memory (1-cycle latency), shown for DWELL cycles, then blanked for
// BLANK cycles. All outputs are registered from the next-state values so they
// line up with the state they describe.
module board_scan_ctrl
  import board_scan_ctrl_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 16,
  parameter int DWELL          = 4,
  parameter int BLANK          = 1,
  parameter int ROW_ACTIVE_LOW = 0,
  localparam int AW = (clog2_f(ROWS) < 1) ? 1 : clog2_f(ROWS),
  localparam int MX = (DWELL > BLANK) ? DWELL : BLANK,
  localparam int CW = clog2_f(MX + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scan_en,
  input  logic            continuous,
  input  logic [COLS-1:0] rd_data,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic [AW-1:0]   row_idx,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [CW-1:0]   DWELL_LD  = CW'(DWELL - 1);
  localparam logic [CW-1:0]   BLANK_LD  = CW'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam logic            HAS_BLANK = (BLANK > 0) ? 1'b1 : 1'b0;
  localparam logic [AW-1:0]   LAST_ROW  = AW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_OFF   = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};
  localparam logic [ROWS-1:0] ROW_ONE   = {{(ROWS-1){1'b0}}, 1'b1};

  scan_state_e     state_r, next_s;
  logic [AW-1:0]   row_idx_r, row_next_s;
  logic [COLS-1:0] shadow_r;
  logic            fd_next_s, eor_s;
  logic            tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [CW-1:0]   tmr_val_s, tmr_value_s;
  logic            rd_en_d_s, busy_d_s;
  logic [ROWS-1:0] row_sel_d_s;
  logic [COLS-1:0] col_data_d_s;

  scan_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .value    (tmr_value_s),
    .zero     (tmr_zero_s)
  );

  // State and row-index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      row_idx_r <= '0;
    end else begin
      state_r   <= next_s;
      row_idx_r <= row_next_s;
    end
  end

  // Next-state, row sequencing and timer control; abort overrides everything
  always_comb begin
    next_s     = state_r;
    row_next_s = row_idx_r;
    fd_next_s  = 1'b0;
    eor_s      = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    tmr_dec_s  = 1'b0;
    if ((state_r != S_IDLE) && !scan_en) begin
      next_s     = S_IDLE;
      row_next_s = '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (scan_en) begin
            next_s     = S_FETCH;
            row_next_s = '0;
          end else begin
            next_s = S_IDLE;
          end
        end
        S_FETCH:   next_s = S_CAPTURE;
        S_CAPTURE: begin
          next_s     = S_SHOW;
          tmr_load_s = 1'b1;
          tmr_val_s  = DWELL_LD;
        end
        S_SHOW: begin
          if (tmr_zero_s && HAS_BLANK) begin
            next_s     = S_BLANK;
            tmr_load_s = 1'b1;
            tmr_val_s  = BLANK_LD;
          end else if (tmr_zero_s) begin
            eor_s = 1'b1;
          end else begin
            tmr_dec_s = (tmr_value_s != '0);
          end
        end
        S_BLANK: begin
          if (tmr_zero_s) begin
            eor_s = 1'b1;
          end else begin
            tmr_dec_s = (tmr_value_s != '0);
          end
        end
        default: begin
          next_s     = S_IDLE;
          row_next_s = '0;
        end
      endcase
      // End of row: advance, or close the frame and decide on a restart
      if (eor_s && (row_idx_r != LAST_ROW)) begin
        row_next_s = row_idx_r + {{(AW-1){1'b0}}, 1'b1};
        next_s     = S_FETCH;
      end else if (eor_s) begin
        row_next_s = '0;
        fd_next_s  = 1'b1;
        next_s     = continuous ? S_FETCH : S_IDLE;
      end else begin
        fd_next_s = 1'b0;
      end
    end
  end

  // Next output values derived from the state being entered
  always_comb begin
    rd_en_d_s    = (next_s == S_FETCH);
    busy_d_s     = (next_s != S_IDLE);
    row_sel_d_s  = ROW_OFF;
    col_data_d_s = '0;
    if (next_s == S_SHOW) begin
      row_sel_d_s  = ROW_OFF ^ (ROW_ONE << row_next_s);
      col_data_d_s = (state_r == S_CAPTURE) ? rd_data : shadow_r;
    end else begin
      row_sel_d_s  = ROW_OFF;
      col_data_d_s = '0;
    end
  end

  // Output registers and the row shadow (memory word captured once per row)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r   <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      row_sel    <= ROW_OFF;
      col_data   <= '0;
      row_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      shadow_r   <= (state_r == S_CAPTURE) ? rd_data : shadow_r;
      rd_en      <= rd_en_d_s;
      rd_addr    <= row_next_s;
      row_sel    <= row_sel_d_s;
      col_data   <= col_data_d_s;
      row_idx    <= row_next_s;
      busy       <= busy_d_s;
      frame_done <= fd_next_s;
    end
  end

endmodule

// File: tb/tb_board_scan_ctrl.sv
// Directed bench for board_scan_ctrl: three instances (default, short 4-row
// no-blank, active-low rows). Expected per-cycle output words are pushed to a
// scoreboard queue when stimulus is applied and popped one per clock.
module tb_board_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic se0, ct0, re0, bz0, fd0;
  logic [2:0] ra0, ri0;
  logic [7:0] rs0;
  logic [15:0] cd0, rdd0;
  // ROWS=4, DWELL=1, BLANK=0
  logic se4, ct4, re4, bz4, fd4;
  logic [1:0] ra4, ri4;
  logic [3:0] rs4;
  logic [15:0] cd4, rdd4;
  // active-low rows
  logic sea, cta, rea, bza, fda;
  logic [2:0] raa, ria;
  logic [7:0] rsa;
  logic [15:0] cda, rdda;

  board_scan_ctrl u_dut0 (.clk(clk), .rst_n(rst_n), .scan_en(se0), .continuous(ct0),
    .rd_data(rdd0), .rd_en(re0), .rd_addr(ra0), .row_sel(rs0), .col_data(cd0),
    .row_idx(ri0), .busy(bz0), .frame_done(fd0));
  board_scan_ctrl #(.ROWS(4), .COLS(16), .DWELL(1), .BLANK(0), .ROW_ACTIVE_LOW(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .scan_en(se4), .continuous(ct4),
    .rd_data(rdd4), .rd_en(re4), .rd_addr(ra4), .row_sel(rs4), .col_data(cd4),
    .row_idx(ri4), .busy(bz4), .frame_done(fd4));
  board_scan_ctrl #(.ROW_ACTIVE_LOW(1)) u_duta (.clk(clk), .rst_n(rst_n), .scan_en(sea),
    .continuous(cta), .rd_data(rdda), .rd_en(rea), .rd_addr(raa), .row_sel(rsa),
    .col_data(cda), .row_idx(ria), .busy(bza), .frame_done(fda));

  // board memory models: row r holds 16'hA000+r, valid only the cycle after rd_en
  logic v0_q, v4_q, va_q;
  logic [2:0] a0_q, aa_q;
  logic [1:0] a4_q;
  always @(posedge clk) begin
    v0_q <= re0; a0_q <= ra0;
    v4_q <= re4; a4_q <= ra4;
    va_q <= rea; aa_q <= raa;
  end
  assign rdd0 = v0_q ? (16'hA000 + {13'd0, a0_q}) : 16'hDEAD;
  assign rdd4 = v4_q ? (16'hA000 + {14'd0, a4_q}) : 16'hDEAD;
  assign rdda = va_q ? (16'hA000 + {13'd0, aa_q}) : 16'hDEAD;

  // observed words {rd_en, rd_addr, row_sel, col_data, busy, frame_done, row_idx}
  wire [32:0] obs0 = {re0, ra0, rs0, cd0, bz0, fd0, ri0};
  wire [32:0] obs4 = {re4, 1'b0, ra4, 4'b0000, rs4, cd4, bz4, fd4, 1'b0, ri4};
  wire [32:0] obsa = {rea, raa, rsa, cda, bza, fda, ria};

  typedef struct {
    int          t;
    int          dut;
    int          c;
    logic [32:0] v;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs c cycles after the first FETCH, from the row/phase timeline
  function automatic logic [32:0] exp_vec(input int c, input int rows, input int d,
                                          input int b, input bit cont, input bit al);
    int p, f, cc, r, ph;
    logic en, bz, fd;
    logic [2:0] ad;
    logic [7:0] rs;
    logic [15:0] cd;
    p = 2 + d + b;
    f = rows * p;
    if (!cont && c >= f) begin
      en = 1'b0; ad = 3'd0; cd = 16'h0000; bz = 1'b0;
      fd = (c == f);
      rs = 8'h00;
    end else begin
      cc = cont ? (c % f) : c;
      r  = cc / p;
      ph = cc % p;
      en = (ph == 0);
      ad = 3'(r);
      bz = 1'b1;
      fd = (c > 0) && (cc == 0);
      rs = (ph >= 2 && ph < 2 + d) ? (8'd1 << r) : 8'h00;
      cd = (ph >= 2 && ph < 2 + d) ? (16'hA000 + 16'(r)) : 16'h0000;
    end
    if (al) rs = rs ^ 8'((1 << rows) - 1);
    return {en, ad, rs, cd, bz, fd, ad};
  endfunction

  function automatic logic [32:0] idle_vec(input bit al);
    logic [7:0] rs;
    rs = al ? 8'hFF : 8'h00;
    return {1'b0, 3'd0, rs, 16'h0000, 1'b0, 1'b0, 3'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int t, input int dut, input int c, input logic [32:0] v);
    exp_t e;
    e.t = t; e.dut = dut; e.c = c; e.v = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input exp_t e);
    logic [32:0] o;
    o = (e.dut == 0) ? obs0 : ((e.dut == 1) ? obs4 : obsa);
    vectors++;
    assert (o === e.v) else begin
      miscompares++;
      $error("FAIL t%0d dut%0d cyc%0d observed %h expected %h", e.t, e.dut, e.c, o, e.v);
    end
  endtask

  // compare immediately (no clock), used around reset
  task automatic cmp_now(input int t, input int dut, input logic [32:0] v);
    exp_t e;
    e.t = t; e.dut = dut; e.c = -1; e.v = v;
    cmp(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      cmp(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    se0 = 1'b0; ct0 = 1'b0; se4 = 1'b0; ct4 = 1'b0; sea = 1'b0; cta = 1'b0;
    repeat (2) step();
    cmp_now(0, 0, idle_vec(1'b0));
    cmp_now(0, 1, idle_vec(1'b0));
    cmp_now(0, 2, idle_vec(1'b1));
    rst_n = 1'b1;
    step();
    cmp_now(0, 0, idle_vec(1'b0));
    cmp_now(0, 2, idle_vec(1'b1));

    // T1: single frame with defaults, then stay idle
    se0 = 1'b1; ct0 = 1'b0;
    for (int c = 0; c <= 56; c++) push(1, 0, c, exp_vec(c, 8, 4, 1, 1'b0, 1'b0));
    drain();
    se0 = 1'b0;
    push(1, 0, 57, exp_vec(57, 8, 4, 1, 1'b0, 1'b0));
    drain();

    // T2: continuous, two back-to-back frames, then abort
    se0 = 1'b1; ct0 = 1'b1;
    for (int c = 0; c <= 112; c++) push(2, 0, c, exp_vec(c, 8, 4, 1, 1'b1, 1'b0));
    drain();
    se0 = 1'b0; ct0 = 1'b0;
    push(2, 0, 113, idle_vec(1'b0));
    drain();

    // T3: abort during SHOW of row 3, re-enable in the abort cycle
    se0 = 1'b1;
    for (int c = 0; c <= 24; c++) push(3, 0, c, exp_vec(c, 8, 4, 1, 1'b0, 1'b0));
    drain();
    se0 = 1'b0;
    push(3, 0, 25, idle_vec(1'b0));
    drain();
    se0 = 1'b1;
    push(3, 0, 0, exp_vec(0, 8, 4, 1, 1'b0, 1'b0));
    push(3, 0, 1, exp_vec(1, 8, 4, 1, 1'b0, 1'b0));
    drain();
    se0 = 1'b0;
    push(3, 0, 2, idle_vec(1'b0));
    drain();

    // T4: ROWS=4, DWELL=1, BLANK=0 -> 3-cycle rows, frame_done at 12
    se4 = 1'b1;
    for (int c = 0; c <= 12; c++) push(4, 1, c, exp_vec(c, 4, 1, 0, 1'b0, 1'b0));
    drain();
    se4 = 1'b0;
    push(4, 1, 13, exp_vec(13, 4, 1, 0, 1'b0, 1'b0));
    drain();

    // T5: active-low rows up to row 2 shown (row_sel 8'hFB)
    sea = 1'b1;
    for (int c = 0; c <= 16; c++) push(5, 2, c, exp_vec(c, 8, 4, 1, 1'b0, 1'b1));
    drain();
    sea = 1'b0;
    push(5, 2, 17, idle_vec(1'b1));
    drain();

    // T6: async reset mid-SHOW, between clock edges
    se0 = 1'b1;
    for (int c = 0; c <= 3; c++) push(6, 0, c, exp_vec(c, 8, 4, 1, 1'b0, 1'b0));
    drain();
    #2;
    rst_n = 1'b0;
    se0 = 1'b0;
    #1;
    cmp_now(6, 0, idle_vec(1'b0));
    cmp_now(6, 2, idle_vec(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cmp_now(6, 0, idle_vec(1'b0));
    se0 = 1'b1;
    push(6, 0, 0, exp_vec(0, 8, 4, 1, 1'b0, 1'b0));
    push(6, 0, 1, exp_vec(1, 8, 4, 1, 1'b0, 1'b0));
    push(6, 0, 2, exp_vec(2, 8, 4, 1, 1'b0, 1'b0));
    drain();
    se0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
